// File: rtl/ad_cache_rd_ctrl_pkg.sv
// Shared constants and FSM encoding for the AD cache read-side scheduler.
// Frame layout: HEAD_WORD, frame counter, HALF_WORDS payload words, then PKTEND.
package ad_cache_rd_ctrl_pkg;

  localparam int          USB_DATA_NBIT     = 16;
  localparam logic [15:0] USB_FRM_HEAD      = 16'hEB90;
  localparam int          AD_CHE_HALF_WORDS = 768;
  localparam int          AD_CHE_RD_LAT     = 2;
  localparam int          AD_CHE_CNT_NBIT   = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR0  = 3'd1,
    ST_HDR1  = 3'd2,
    ST_READ  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_END   = 3'd5
  } rd_state_t;

endpackage

// File: rtl/ad_rd_delay.sv
// Strobe shift register: dout follows din after STAGES clocks.
// Async clear drops every in-flight strobe.
module ad_rd_delay #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[STAGES-1];

endmodule

// File: rtl/ad_cache_rd_ctrl.sv
// Drains the idle half of the AD ping-pong cache into the USB FIFO on each switch toggle,
// framing it with header + frame counter and a trailing PKTEND; flags overrun on early toggles.
module ad_cache_rd_ctrl
  import ad_cache_rd_ctrl_pkg::*;
#(
  parameter int          HALF_WORDS = AD_CHE_HALF_WORDS,
  parameter int          RD_LAT     = AD_CHE_RD_LAT,
  parameter logic [15:0] HEAD_WORD  = USB_FRM_HEAD,
  parameter int          CNT_NBIT   = AD_CHE_CNT_NBIT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     switch,
  output logic                     cache_rd,
  input  logic [USB_DATA_NBIT-1:0] cache_rdata,
  input  logic                     fifo_afull,
  output logic                     fifo_wr,
  output logic [USB_DATA_NBIT-1:0] fifo_wdata,
  output logic                     fifo_pktend,
  output logic                     busy,
  output logic [15:0]              frame_cnt,
  output logic                     overrun
);

  rd_state_t                st, st_nxt;
  logic [CNT_NBIT-1:0]      wcnt, wcnt_nxt;
  logic                     switch_d, primed, tgl;
  logic                     hdr_wr, pay_vld;
  logic [USB_DATA_NBIT-1:0] hdr_dat;

  // primed masks the first cycle after reset so the history register can load first
  assign tgl = primed & (switch ^ switch_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      switch_d <= 1'b0;
      primed   <= 1'b0;
    end else begin
      switch_d <= switch;
      primed   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= ST_IDLE;
      wcnt <= '0;
    end else begin
      st   <= st_nxt;
      wcnt <= wcnt_nxt;
    end
  end

  always_comb begin
    st_nxt   = st;
    wcnt_nxt = wcnt;
    cache_rd = 1'b0;
    hdr_wr   = 1'b0;
    hdr_dat  = HEAD_WORD;
    case (st)
      ST_IDLE: if (tgl && en) st_nxt = ST_HDR0;
      ST_HDR0: begin
        if (!fifo_afull) begin
          hdr_wr = 1'b1;
          st_nxt = ST_HDR1;
        end
      end
      ST_HDR1: begin
        hdr_dat = frame_cnt;
        if (!fifo_afull) begin
          hdr_wr = 1'b1;
          st_nxt = ST_READ;
        end
      end
      ST_READ: begin
        if (!fifo_afull) begin
          cache_rd = 1'b1;
          if (wcnt == CNT_NBIT'(HALF_WORDS-1)) begin
            wcnt_nxt = '0;
            st_nxt   = ST_DRAIN;
          end else begin
            wcnt_nxt = wcnt + CNT_NBIT'(1);
          end
        end
      end
      // the word counter is reused to time out the read latency
      ST_DRAIN: begin
        if (wcnt == CNT_NBIT'(RD_LAT-1)) begin
          wcnt_nxt = '0;
          st_nxt   = ST_END;
        end else begin
          wcnt_nxt = wcnt + CNT_NBIT'(1);
        end
      end
      ST_END:  st_nxt = ST_IDLE;
      default: st_nxt = ST_IDLE;
    endcase
  end

  ad_rd_delay #(.STAGES(RD_LAT)) u_rd_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (cache_rd),
    .dout  (pay_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr     <= 1'b0;
      fifo_wdata  <= '0;
      fifo_pktend <= 1'b0;
      frame_cnt   <= '0;
      overrun     <= 1'b0;
    end else begin
      fifo_wr     <= hdr_wr | pay_vld;
      if (pay_vld)     fifo_wdata <= cache_rdata;
      else if (hdr_wr) fifo_wdata <= hdr_dat;
      fifo_pktend <= (st == ST_END);
      if (st == ST_END) frame_cnt <= frame_cnt + 16'd1;
      if (tgl && st != ST_IDLE)     overrun <= 1'b1;
      else if (!en && st == ST_IDLE) overrun <= 1'b0;
    end
  end

  // registered PKTEND trails END by a cycle, so busy is extended to cover it
  assign busy = (st != ST_IDLE) || fifo_pktend;

endmodule
